pipe_hazard_ctrl: RTL and testbench

- Hazard and sequencing controller for the 5-stage pipeline.
- Produces the stall/no-write and flush controls that drive the PC register, the IF/ID register (its Flush/NW inputs), ID/EX, EX/MEM and MEM/WB.
- Resolves three hazard classes with fixed priority: data-memory wait > taken branch > load-use.
- Multi-cycle stalls and flushes are sequenced by a small FSM with a shared down-counter.

---
 rtl/pipe_ctrl_pkg.sv | 14 +
 rtl/haz_sat_cnt16.sv | 29 ++
 rtl/pipe_hazard_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  localparam int REG_AW_DEF = 3;
  localparam int CNT_W      = 3;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    BR_FLUSH = 2'd2,
    MEM_WAIT = 2'd3
  } haz_state_e;

endpackage

// File: rtl/haz_sat_cnt16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module haz_sat_cnt16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] count
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory wait > taken branch > load-use.
// Define HAZ_PERF_CNT_EN to build the stall/flush performance counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW    = REG_AW_DEF,
  parameter int LU_CYCLES = 1,
  parameter int BR_SHADOW = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              branch_taken,
  input  logic              mem_busy,
  output logic              pc_hold,
  output logic              pc_sel_br,
  output logic              ifid_nw,
  output logic              ifid_flush,
  output logic              idex_nw,
  output logic              idex_flush,
  output logic              exmem_nw,
  output logic              memwb_flush,
  output logic [15:0]       perf_stall,
  output logic [15:0]       perf_flush
);

  localparam logic [CNT_W-1:0] LU_RELOAD = CNT_W'(LU_CYCLES - 2);
  localparam logic [CNT_W-1:0] BR_RELOAD = CNT_W'(BR_SHADOW - 1);

  haz_state_e       state_q, state_d;
  haz_state_e       ret_q, ret_d;
  haz_state_e       eff_state;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu_hit;
  logic             take_br;
  logic             pc_hold_c, pc_sel_br_c, ifid_nw_c, ifid_flush_c;
  logic             idex_nw_c, idex_flush_c, exmem_nw_c, memwb_flush_c;

  assign lu_hit = id_valid && ex_memread && (ex_rd != '0) &&
                  ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

  // A memory wait only parks the sequence; once released, the saved state
  // is evaluated in the same cycle as if the wait never happened.
  assign eff_state = (state_q == MEM_WAIT) ? ret_q : state_q;
  assign take_br   = branch_taken && (eff_state != MEM_WAIT);

  always_comb begin
    state_d       = state_q;
    ret_d         = ret_q;
    cnt_d         = cnt_q;
    pc_hold_c     = 1'b0;
    pc_sel_br_c   = 1'b0;
    ifid_nw_c     = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_nw_c     = 1'b0;
    idex_flush_c  = 1'b0;
    exmem_nw_c    = 1'b0;
    memwb_flush_c = 1'b0;

    if (mem_busy) begin
      pc_hold_c     = 1'b1;
      ifid_nw_c     = 1'b1;
      idex_nw_c     = 1'b1;
      exmem_nw_c    = 1'b1;
      memwb_flush_c = 1'b1;
      state_d       = MEM_WAIT;
      ret_d         = eff_state;
    end else if (take_br) begin
      pc_sel_br_c  = 1'b1;
      ifid_flush_c = 1'b1;
      idex_flush_c = 1'b1;
      ret_d        = RUN;
      if (BR_SHADOW > 0) begin
        state_d = BR_FLUSH;
        cnt_d   = BR_RELOAD;
      end else begin
        state_d = RUN;
        cnt_d   = '0;
      end
    end else begin
      ret_d   = RUN;
      state_d = eff_state;
      case (eff_state)
        RUN: begin
          if (lu_hit) begin
            pc_hold_c    = 1'b1;
            ifid_nw_c    = 1'b1;
            idex_flush_c = 1'b1;
            if (LU_CYCLES > 1) begin
              state_d = LU_STALL;
              cnt_d   = LU_RELOAD;
            end
          end
        end
        LU_STALL: begin
          pc_hold_c    = 1'b1;
          ifid_nw_c    = 1'b1;
          idex_flush_c = 1'b1;
          if (cnt_q == '0) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        BR_FLUSH: begin
          ifid_flush_c = 1'b1;
          if (cnt_q == '0) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      ret_q   <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced quiet for the whole reset pulse, not just after the edge.
  assign pc_hold     = pc_hold_c     & ~rst;
  assign pc_sel_br   = pc_sel_br_c   & ~rst;
  assign ifid_nw     = ifid_nw_c     & ~rst;
  assign ifid_flush  = ifid_flush_c  & ~rst;
  assign idex_nw     = idex_nw_c     & ~rst;
  assign idex_flush  = idex_flush_c  & ~rst;
  assign exmem_nw    = exmem_nw_c    & ~rst;
  assign memwb_flush = memwb_flush_c & ~rst;

`ifdef HAZ_PERF_CNT_EN
  haz_sat_cnt16 u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pc_hold),
    .count (perf_stall)
  );

  haz_sat_cnt16 u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pc_sel_br),
    .count (perf_flush)
  );
`else
  assign perf_stall = '0;
  assign perf_flush = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: dut_a (LU_CYCLES=1, BR_SHADOW=0), dut_b (LU_CYCLES=3, BR_SHADOW=2).
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_uses_rt, ex_memread, branch_taken, mem_busy;
  logic [2:0] id_rs, id_rt, ex_rd;

  logic pc_hold_a, pc_sel_br_a, ifid_nw_a, ifid_flush_a;
  logic idex_nw_a, idex_flush_a, exmem_nw_a, memwb_flush_a;
  logic pc_hold_b, pc_sel_br_b, ifid_nw_b, ifid_flush_b;
  logic idex_nw_b, idex_flush_b, exmem_nw_b, memwb_flush_b;
  logic [15:0] perf_stall_a, perf_flush_a, perf_stall_b, perf_flush_b;
  logic [7:0]  out_a, out_b;

  // Output vector order: pc_hold, pc_sel_br, ifid_nw, ifid_flush, idex_nw, idex_flush, exmem_nw, memwb_flush
  localparam logic [7:0] V_IDLE = 8'h00;
  localparam logic [7:0] V_LU   = 8'hA4;
  localparam logic [7:0] V_BR   = 8'h54;
  localparam logic [7:0] V_SH   = 8'h10;
  localparam logic [7:0] V_MEM  = 8'hAB;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  assign out_a = {pc_hold_a, pc_sel_br_a, ifid_nw_a, ifid_flush_a,
                  idex_nw_a, idex_flush_a, exmem_nw_a, memwb_flush_a};
  assign out_b = {pc_hold_b, pc_sel_br_b, ifid_nw_b, ifid_flush_b,
                  idex_nw_b, idex_flush_b, exmem_nw_b, memwb_flush_b};

  pipe_hazard_ctrl #(.REG_AW(3), .LU_CYCLES(1), .BR_SHADOW(0)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_hold(pc_hold_a), .pc_sel_br(pc_sel_br_a), .ifid_nw(ifid_nw_a),
    .ifid_flush(ifid_flush_a), .idex_nw(idex_nw_a), .idex_flush(idex_flush_a),
    .exmem_nw(exmem_nw_a), .memwb_flush(memwb_flush_a),
    .perf_stall(perf_stall_a), .perf_flush(perf_flush_a)
  );

  pipe_hazard_ctrl #(.REG_AW(3), .LU_CYCLES(3), .BR_SHADOW(2)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_hold(pc_hold_b), .pc_sel_br(pc_sel_br_b), .ifid_nw(ifid_nw_b),
    .ifid_flush(ifid_flush_b), .idex_nw(idex_nw_b), .idex_flush(idex_flush_b),
    .exmem_nw(exmem_nw_b), .memwb_flush(memwb_flush_b),
    .perf_stall(perf_stall_b), .perf_flush(perf_flush_b)
  );

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drive_in(input logic idv, input logic mr, input logic [2:0] rd,
                          input logic [2:0] rs, input logic [2:0] rt, input logic urt,
                          input logic br, input logic mb);
    id_valid     = idv;
    ex_memread   = mr;
    ex_rd        = rd;
    id_rs        = rs;
    id_rt        = rt;
    id_uses_rt   = urt;
    branch_taken = br;
    mem_busy     = mb;
  endtask

  task automatic clear_in();
    drive_in(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Called just after a rising edge; compares one scoreboard entry mid-cycle.
  task automatic step_check(input bit use_b, input string tag);
    logic [7:0] e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got %h", tag, use_b ? out_b : out_a);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, use_b ? out_b : out_a, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_in();
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check_eq("inv_ifid_a", 16'(ifid_nw_a & ifid_flush_a), 16'd0);
      check_eq("inv_pc_a",   16'(pc_hold_a & pc_sel_br_a),  16'd0);
      check_eq("inv_ifid_b", 16'(ifid_nw_b & ifid_flush_b), 16'd0);
      check_eq("inv_pc_b",   16'(pc_hold_b & pc_sel_br_b),  16'd0);
    end
  end

  initial begin
    logic       idv, mr, urt, hit;
    logic [2:0] rd, rs, rt;

    // Outputs must stay low while reset is held, whatever the inputs say.
    rst = 1'b1;
    drive_in(1'b1, 1'b1, 3'd3, 3'd3, 3'd0, 1'b0, 1'b1, 1'b1);
    #2;
    check_eq("rst_out_a", 16'(out_a), 16'd0);
    check_eq("rst_out_b", 16'(out_b), 16'd0);
    clear_in();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Load-use with LU_CYCLES=1: single bubble, then quiet.
    do_reset();
    exp_q.push_back(V_LU);
    exp_q.push_back(V_IDLE);
    drive_in(1'b1, 1'b1, 3'd3, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0);
    step_check(1'b0, "lu1_stall");
    clear_in();
    step_check(1'b0, "lu1_after");

    do_reset();
    exp_q.push_back(V_IDLE);
    drive_in(1'b1, 1'b1, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    step_check(1'b0, "lu1_rd0");

    // Load-use on rt with LU_CYCLES=3: exactly three stall cycles.
    do_reset();
    repeat (3) exp_q.push_back(V_LU);
    exp_q.push_back(V_IDLE);
    drive_in(1'b1, 1'b1, 3'd2, 3'd5, 3'd2, 1'b1, 1'b0, 1'b0);
    step_check(1'b1, "lu3_c0");
    clear_in();
    step_check(1'b1, "lu3_c1");
    step_check(1'b1, "lu3_c2");
    step_check(1'b1, "lu3_c3");

    do_reset();
    exp_q.push_back(V_IDLE);
    drive_in(1'b1, 1'b1, 3'd2, 3'd5, 3'd2, 1'b0, 1'b0, 1'b0);
    step_check(1'b1, "lu3_no_rt");

    // Branch and load-use together, BR_SHADOW=2: branch wins, then shadow flushes.
    do_reset();
    exp_q.push_back(V_BR);
    exp_q.push_back(V_SH);
    exp_q.push_back(V_SH);
    exp_q.push_back(V_IDLE);
    drive_in(1'b1, 1'b1, 3'd3, 3'd3, 3'd0, 1'b0, 1'b1, 1'b0);
    step_check(1'b1, "br2_c0");
    clear_in();
    step_check(1'b1, "br2_c1");
    step_check(1'b1, "br2_c2");
    step_check(1'b1, "br2_c3");

    // Same with BR_SHADOW=0: one flush cycle only.
    do_reset();
    exp_q.push_back(V_BR);
    exp_q.push_back(V_IDLE);
    drive_in(1'b1, 1'b1, 3'd3, 3'd3, 3'd0, 1'b0, 1'b1, 1'b0);
    step_check(1'b0, "br0_c0");
    clear_in();
    step_check(1'b0, "br0_c1");

    // Memory wait for 4 cycles after the first load-use stall cycle.
    do_reset();
    exp_q.push_back(V_LU);
    repeat (4) exp_q.push_back(V_MEM);
    exp_q.push_back(V_LU);
    exp_q.push_back(V_LU);
    exp_q.push_back(V_IDLE);
    drive_in(1'b1, 1'b1, 3'd4, 3'd4, 3'd0, 1'b0, 1'b0, 1'b0);
    step_check(1'b1, "mem_lu_c0");
    drive_in(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    repeat (4) step_check(1'b1, "mem_freeze");
    clear_in();
    step_check(1'b1, "mem_resume1");
    step_check(1'b1, "mem_resume2");
    step_check(1'b1, "mem_done");

    // Random load-use detection against the hazard equation (LU_CYCLES=1 has no state).
    do_reset();
    for (int i = 0; i < 32; i++) begin
      idv = ($urandom_range(0, 3) != 0);
      mr  = 1'($urandom_range(0, 1));
      urt = 1'($urandom_range(0, 1));
      rd  = 3'($urandom_range(0, 7));
      rs  = ($urandom_range(0, 2) == 0) ? rd : 3'($urandom_range(0, 7));
      rt  = ($urandom_range(0, 2) == 0) ? rd : 3'($urandom_range(0, 7));
      hit = idv && mr && (rd != 3'd0) && ((rd == rs) || (urt && (rd == rt)));
      exp_q.push_back(hit ? V_LU : V_IDLE);
      drive_in(idv, mr, rd, rs, rt, urt, 1'b0, 1'b0);
      step_check(1'b0, "rand_lu");
    end

    // Asynchronous reset in the middle of the branch shadow.
    do_reset();
    exp_q.push_back(V_BR);
    drive_in(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0);
    step_check(1'b1, "rstbr_c0");
    clear_in();
    #1;
    check_eq("rstbr_pre", 16'(ifid_flush_b), 16'd1);
    rst = 1'b1;
    #1;
    check_eq("rstbr_out", 16'(out_b), 16'd0);
`ifdef HAZ_PERF_CNT_EN
    check_eq("rstbr_perf_s", perf_stall_b, 16'd0);
    check_eq("rstbr_perf_f", perf_flush_b, 16'd0);
`endif
    #1;
    rst = 1'b0;
    exp_q.push_back(V_IDLE);
    step_check(1'b1, "rstbr_run");
    check_eq("rstbr_state", 16'(dut_b.state_q), 16'd0);

`ifdef HAZ_PERF_CNT_EN
    do_reset();
    drive_in(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    clear_in();
    check_eq("perf_flush_a", perf_flush_a, 16'd3);
    mem_busy = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    check_eq("perf_sat", perf_stall_a, 16'hFFFF);
    repeat (5) @(posedge clk);
    #1;
    check_eq("perf_sat_hold", perf_stall_a, 16'hFFFF);
    clear_in();
`else
    check_eq("perf_tie_s", perf_stall_a, 16'd0);
    check_eq("perf_tie_f", perf_flush_b, 16'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
